// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration on ties).
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_BEATS  = 4;

    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2,
        RRESP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arb_beat_cnt.sv
// Beat counter for one line burst: cleared at the request handshake,
// incremented per data/response beat, flags the final beat and wraps to 0 after it.
module mem_arb_beat_cnt
    import mem_arb_pkg::*;
#(
    parameter int BEATS = DEF_BEATS,
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign last = (cnt_reg == CNT_W'(BEATS - 1));

    // Next count: clear wins, the final beat wraps back to zero.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc) begin
            cnt_next = last ? '0 : cnt_reg + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (icache refill / dcache refill+writeback) in front of
// the single main-memory port. One line transaction at a time: one request
// handshake followed by BEATS data or response beats.
// Optional feature macro: MEM_ARB_RR_EN (round-robin on ties; otherwise the
// dcache always wins).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BEATS  = DEF_BEATS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ic_req_valid,
    output logic                ic_req_ready,
    input  logic [ADDR_W-1:0]   ic_req_addr,
    output logic                ic_resp_valid,
    output logic [DATA_W-1:0]   ic_resp_data,
    input  logic                dc_req_valid,
    output logic                dc_req_ready,
    input  logic                dc_req_rw,
    input  logic [ADDR_W-1:0]   dc_req_addr,
    input  logic                dc_req_data_valid,
    output logic                dc_req_data_ready,
    input  logic [DATA_W-1:0]   dc_req_data_bits,
    input  logic [DATA_W/8-1:0] dc_req_data_mask,
    output logic                dc_resp_valid,
    output logic [DATA_W-1:0]   dc_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_data_valid,
    input  logic                mem_req_data_ready,
    output logic [DATA_W-1:0]   mem_req_data_bits,
    output logic [DATA_W/8-1:0] mem_req_data_mask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    output logic                arb_busy,
    output logic                arb_owner
);

    arb_state_e        state_reg;
    arb_state_e        state_next;
    logic              owner_reg;
    logic              rw_reg;
    logic [ADDR_W-1:0] addr_reg;

    logic any_req;
    logic grant_dc;
    logic capture;
    logic req_hs;
    logic wdata_hs;
    logic rresp_beat;
    logic beat_last;

    assign any_req    = ic_req_valid | dc_req_valid;
    assign capture    = (state_reg == IDLE) & any_req;
    assign req_hs     = (state_reg == REQ) & mem_req_ready;
    assign wdata_hs   = (state_reg == WDATA) & dc_req_data_valid & mem_req_data_ready;
    assign rresp_beat = (state_reg == RRESP) & mem_resp_valid;

`ifdef MEM_ARB_RR_EN
    logic last_owner_reg;

    // On a tie the requester that did not own the previous transaction wins.
    always_comb begin
        grant_dc = dc_req_valid;
        if (ic_req_valid && dc_req_valid) begin
            grant_dc = (last_owner_reg == OWNER_IC);
        end
    end

    // Remember who was granted last; starts as dcache so the icache wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner_reg <= OWNER_DC;
        end else if (capture) begin
            last_owner_reg <= grant_dc ? OWNER_DC : OWNER_IC;
        end
    end
`else
    // Fixed priority: the dcache wins whenever it is requesting.
    always_comb begin
        grant_dc = dc_req_valid;
    end
`endif

    // Latch the winning request's owner, direction and address in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_reg <= OWNER_IC;
            rw_reg    <= 1'b0;
            addr_reg  <= '0;
        end else if (capture) begin
            owner_reg <= grant_dc ? OWNER_DC : OWNER_IC;
            rw_reg    <= grant_dc ? dc_req_rw : 1'b0;
            addr_reg  <= grant_dc ? dc_req_addr : ic_req_addr;
        end
    end

    mem_arb_beat_cnt #(
        .BEATS (BEATS)
    ) u_beat_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (req_hs),
        .inc     (wdata_hs | rresp_beat),
        .last    (beat_last)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = REQ;
            REQ:     if (mem_req_ready) state_next = rw_reg ? WDATA : RRESP;
            WDATA:   if (wdata_hs && beat_last) state_next = IDLE;
            RRESP:   if (rresp_beat && beat_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: request, write-beat and response routing per state.
    always_comb begin
        ic_req_ready       = 1'b0;
        dc_req_ready       = 1'b0;
        ic_resp_valid      = 1'b0;
        ic_resp_data       = '0;
        dc_resp_valid      = 1'b0;
        dc_resp_data       = '0;
        dc_req_data_ready  = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;
        case (state_reg)
            REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = rw_reg;
                mem_req_addr  = addr_reg;
                if (owner_reg == OWNER_DC) begin
                    dc_req_ready = mem_req_ready;
                end else begin
                    ic_req_ready = mem_req_ready;
                end
            end
            WDATA: begin
                mem_req_data_valid = dc_req_data_valid;
                mem_req_data_bits  = dc_req_data_bits;
                mem_req_data_mask  = dc_req_data_mask;
                dc_req_data_ready  = mem_req_data_ready;
            end
            RRESP: begin
                if (owner_reg == OWNER_DC) begin
                    dc_resp_valid = mem_resp_valid;
                    dc_resp_data  = mem_resp_data;
                end else begin
                    ic_resp_valid = mem_resp_valid;
                    ic_resp_data  = mem_resp_data;
                end
            end
            default: begin
            end
        endcase
    end

    assign arb_busy  = (state_reg != IDLE);
    assign arb_owner = owner_reg;

endmodule
